// File: rtl/axis_pkg.sv
// Shared defaults for the AXI-Stream word packer: word/bus widths and lane-index width.
package axis_pkg;

  localparam int WORD_W_DEF = 8;
  localparam int BUS_W_DEF  = 32;
  localparam int WPB_DEF    = BUS_W_DEF / WORD_W_DEF;
  localparam int IDX_W_DEF  = $clog2(WPB_DEF);

endpackage

// File: rtl/axis_word_packer_if.sv
// Word-in / beat-out stream bundle. The packer uses the slave view; the
// environment (upstream source plus downstream sink) uses the master view.
interface axis_word_packer_if
  import axis_pkg::*;
#(
  parameter int WORD_W         = WORD_W_DEF,
  parameter int WORDS_PER_BEAT = WPB_DEF
);

  logic                                  s_valid;
  logic                                  s_ready;
  logic signed [WORD_W-1:0]              s_data;
  logic                                  s_last;
  logic                                  m_valid;
  logic                                  m_ready;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] m_data;
  logic [WORDS_PER_BEAT-1:0]             m_keep;
  logic                                  m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

endinterface

// File: rtl/axis_out_reg.sv
// Output beat register: loads a full beat on i_load, holds it until the consumer
// takes it, then drops valid unless a new beat is loaded at the same edge.
module axis_out_reg
  import axis_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int LANES  = WPB_DEF
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_load,
  input  logic                         i_ready,
  input  logic [LANES-1:0][WORD_W-1:0] i_data,
  input  logic [LANES-1:0]             i_keep,
  input  logic                         i_last,
  output logic                         o_valid,
  output logic [LANES-1:0][WORD_W-1:0] o_data,
  output logic [LANES-1:0]             o_keep,
  output logic                         o_last
);

  logic                         r_valid;
  logic [LANES-1:0][WORD_W-1:0] r_data;
  logic [LANES-1:0]             r_keep;
  logic                         r_last;

  // Caller only asserts i_load when the slot is free, so load wins over drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

endmodule

// File: rtl/axis_word_packer.sv
// Packs a stream of WORD_W words into WORDS_PER_BEAT-lane beats, lane 0 first;
// a packet end flushes a partial beat with a contiguous keep mask.
module axis_word_packer
  import axis_pkg::*;
#(
  parameter int WORD_W         = WORD_W_DEF,
  parameter int BUS_W          = BUS_W_DEF,
  parameter int WORDS_PER_BEAT = BUS_W / WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  axis_word_packer_if.slave  bus
);

  localparam int               IDX_W    = $clog2(WORDS_PER_BEAT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BEAT - 1);

  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] r_buf;
  logic [WORDS_PER_BEAT-1:0]             r_keep;
  logic                                  r_last;
  logic [IDX_W-1:0]                      r_idx;
  logic                                  r_pending;

  logic                                  w_accept;
  logic                                  w_complete;
  logic                                  w_slot_free;
  logic                                  w_load;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] w_fill_data;
  logic [WORDS_PER_BEAT-1:0]             w_fill_keep;
  logic [WORDS_PER_BEAT-1:0][WORD_W-1:0] w_load_data;
  logic [WORDS_PER_BEAT-1:0]             w_load_keep;
  logic                                  w_load_last;

  assign bus.s_ready = !r_pending;
  assign w_accept    = bus.s_valid && !r_pending;
  assign w_slot_free = !bus.m_valid || bus.m_ready;
  assign w_complete  = w_accept && ((r_idx == LAST_IDX) || bus.s_last);
  assign w_load      = w_slot_free && (r_pending || w_complete);

  // Fill buffer as it would look with the incoming word dropped into lane r_idx.
  generate
    for (genvar gi = 0; gi < WORDS_PER_BEAT; gi++) begin : g_lane
      assign w_fill_data[gi] = (w_accept && (r_idx == IDX_W'(gi))) ? bus.s_data : r_buf[gi];
      assign w_fill_keep[gi] = r_keep[gi] || (w_accept && (r_idx == IDX_W'(gi)));
    end
  endgenerate

  assign w_load_data = r_pending ? r_buf  : w_fill_data;
  assign w_load_keep = r_pending ? r_keep : w_fill_keep;
  assign w_load_last = r_pending ? r_last : bus.s_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf     <= '0;
      r_keep    <= '0;
      r_last    <= 1'b0;
      r_idx     <= '0;
      r_pending <= 1'b0;
    end else if (r_pending) begin
      if (w_slot_free) begin
        r_buf     <= '0;
        r_keep    <= '0;
        r_last    <= 1'b0;
        r_idx     <= '0;
        r_pending <= 1'b0;
      end
    end else if (w_accept) begin
      if (w_complete && w_slot_free) begin
        r_buf  <= '0;
        r_keep <= '0;
        r_last <= 1'b0;
        r_idx  <= '0;
      end else if (w_complete) begin
        r_buf     <= w_fill_data;
        r_keep    <= w_fill_keep;
        r_last    <= bus.s_last;
        r_pending <= 1'b1;
      end else begin
        r_buf  <= w_fill_data;
        r_keep <= w_fill_keep;
        r_idx  <= r_idx + IDX_W'(1);
      end
    end
  end

  axis_out_reg #(
    .WORD_W (WORD_W),
    .LANES  (WORDS_PER_BEAT)
  ) u_out_reg (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_ready (bus.m_ready),
    .i_data  (w_load_data),
    .i_keep  (w_load_keep),
    .i_last  (w_load_last),
    .o_valid (bus.m_valid),
    .o_data  (bus.m_data),
    .o_keep  (bus.m_keep),
    .o_last  (bus.m_last)
  );

endmodule

// File: tb/tb_axis_word_packer.sv
// Directed and randomized checks of axis_word_packer with WORD_W=8, BUS_W=32.
module tb_axis_word_packer;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_word_packer_if #(.WORD_W(8), .WORDS_PER_BEAT(4)) bus ();

  axis_word_packer #(
    .WORD_W (8),
    .BUS_W  (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_chk       = 0;
  int    n_pass      = 0;
  int    n_fail      = 0;
  int    cyc         = 0;
  int    n_stab_viol = 0;
  int    n_beats     = 0;
  beat_t got_q[$];
  beat_t exp_q[$];
  logic  prev_hold   = 1'b0;
  logic [37:0] prev_snap = '0;

  always @(posedge clk) cyc++;

  // Beat capture and hold-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [37:0] snap;
    snap = {bus.m_valid, bus.m_data, bus.m_keep, bus.m_last};
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (snap !== prev_snap)) n_stab_viol++;
      if (bus.m_valid && bus.m_ready) begin
        got_q.push_back('{data: bus.m_data, keep: bus.m_keep, last: bus.m_last});
        n_beats++;
        if (n_beats <= 40)
          $display("beat %0d data=%h keep=%b last=%b", n_beats, bus.m_data, bus.m_keep, bus.m_last);
      end
      prev_hold = bus.m_valid && !bus.m_ready;
      prev_snap = snap;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected finish (%0d errors so far)", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t;
    t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    @(negedge clk);
    while (!bus.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 64'(t), 64'd0);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int i, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    beat_t b;
    if (i < got_q.size()) begin
      b = got_q[i];
    end else begin
      b.data = 'x;
      b.keep = 'x;
      b.last = 1'bx;
    end
    check({tag, "_data"}, 64'(b.data), 64'(d));
    check({tag, "_keep"}, 64'(b.keep), 64'(k));
    check({tag, "_last"}, 64'(b.last), 64'(l));
  endtask

  initial begin
    int          c0;
    int          len;
    int          lane;
    int          t;
    int          n_mis;
    int          n_nc;
    int          n_last;
    logic [7:0]  d;
    logic [31:0] acc;
    logic [3:0]  kacc;
    logic        done;

    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) tick();
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_data",  64'(bus.m_data),  64'd0);
    check("rst_m_keep",  64'(bus.m_keep),  64'd0);
    check("rst_m_last",  64'(bus.m_last),  64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd1);
    rst = 1'b0;

    // Eight words, two full beats, back to back from the first edge after reset.
    bus.m_ready = 1'b1;
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
    check("t1_cycles", 64'(cyc - c0), 64'd8);
    repeat (3) tick();
    check("t1_count", 64'(got_q.size()), 64'd2);
    check_beat("t1_b0", 0, 32'h04030201, 4'b1111, 1'b0);
    check_beat("t1_b1", 1, 32'h08070605, 4'b1111, 1'b1);
    got_q.delete();

    // Five words: trailing partial beat with zeroed unused lanes.
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
    repeat (3) tick();
    check("t2_count", 64'(got_q.size()), 64'd2);
    check_beat("t2_b0", 0, 32'h04030201, 4'b1111, 1'b0);
    check_beat("t2_b1", 1, 32'h00000005, 4'b0001, 1'b1);
    got_q.delete();

    // Single-word packet: beat visible right after the accepting edge.
    send(8'h80, 1'b1);
    check("t3_m_valid", 64'(bus.m_valid), 64'd1);
    check("t3_m_data",  64'(bus.m_data),  64'h00000080);
    check("t3_lane0",   64'($signed(bus.m_data[0])), 64'(-128));
    check("t3_m_keep",  64'(bus.m_keep),  64'h1);
    check("t3_m_last",  64'(bus.m_last),  64'd1);
    tick();
    check("t3_m_valid_fall", 64'(bus.m_valid), 64'd0);
    check("t3_count", 64'(got_q.size()), 64'd1);
    got_q.delete();

    // Backpressure: second beat parks in the fill buffer, input stalls.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), i == 7);
    check("t4_s_ready_drop", 64'(bus.s_ready), 64'd0);
    check("t4_hold_data",    64'(bus.m_data),  64'h14131211);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h99;
    bus.s_last  = 1'b1;
    repeat (10) tick();
    check("t4_s_ready_held", 64'(bus.s_ready), 64'd0);
    check("t4_still_data",   64'(bus.m_data),  64'h14131211);
    check("t4_still_valid",  64'(bus.m_valid), 64'd1);
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    check("t4_next_data",    64'(bus.m_data),  64'h18171615);
    check("t4_next_last",    64'(bus.m_last),  64'd1);
    check("t4_s_ready_back", 64'(bus.s_ready), 64'd1);
    repeat (3) tick();
    check("t4_count", 64'(got_q.size()), 64'd2);
    check_beat("t4_b0", 0, 32'h14131211, 4'b1111, 1'b0);
    check_beat("t4_b1", 1, 32'h18171615, 4'b1111, 1'b1);
    check("t4_stability", 64'(n_stab_viol), 64'd0);
    got_q.delete();

    // Asynchronous reset mid-packet with a beat parked at the output.
    bus.m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(8'(i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("t5_rst_m_data",  64'(bus.m_data),  64'd0);
    check("t5_rst_m_keep",  64'(bus.m_keep),  64'd0);
    check("t5_rst_m_last",  64'(bus.m_last),  64'd0);
    check("t5_rst_s_ready", 64'(bus.s_ready), 64'd1);
    tick();
    rst = 1'b0;
    bus.m_ready = 1'b1;
    c0 = cyc;
    for (int i = 9; i <= 12; i++) send(8'(i), i == 12);
    check("t5_cycles", 64'(cyc - c0), 64'd4);
    repeat (3) tick();
    check("t5_count", 64'(got_q.size()), 64'd1);
    check_beat("t5_b0", 0, 32'h0c0b0a09, 4'b1111, 1'b1);
    got_q.delete();

    // Random valid/ready gaps over many packets of length 1..17.
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 1000; p++) begin
          len  = $urandom_range(1, 17);
          acc  = '0;
          kacc = '0;
          lane = 0;
          for (int w = 0; w < len; w++) begin
            d = 8'($urandom);
            while ($urandom_range(0, 4) == 0) tick();
            send(d, w == len - 1);
            acc[lane*8 +: 8] = d;
            kacc[lane]       = 1'b1;
            lane++;
            if (lane == 4 || w == len - 1) begin
              exp_q.push_back('{data: acc, keep: kacc, last: (w == len - 1)});
              acc  = '0;
              kacc = '0;
              lane = 0;
            end
          end
        end
        t = 0;
        while ((got_q.size() < exp_q.size() || bus.m_valid) && t < 5000) begin
          tick();
          t++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus.m_ready = ($urandom_range(0, 4) != 0);
        end
      end
    join
    bus.m_ready = 1'b1;

    n_mis  = 0;
    n_nc   = 0;
    n_last = 0;
    foreach (got_q[i]) begin
      if (i < exp_q.size()) begin
        if (got_q[i].data !== exp_q[i].data || got_q[i].keep !== exp_q[i].keep ||
            got_q[i].last !== exp_q[i].last)
          n_mis++;
      end
      if (!(got_q[i].keep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})) n_nc++;
      if (got_q[i].last === 1'b1) n_last++;
    end
    check("t6_beat_count",   64'(got_q.size()), 64'(exp_q.size()));
    check("t6_beat_mismatch", 64'(n_mis),       64'd0);
    check("t6_keep_contig",  64'(n_nc),         64'd0);
    check("t6_last_count",   64'(n_last),       64'd1000);
    check("t6_stability",    64'(n_stab_viol),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
